xilinx_dram_fifo: RTL and testbench



---
 rtl/xilinx_dram_fifo_pkg.sv | 17 +
 rtl/xilinx_dram_fifo_mem.sv | 21 ++
 rtl/xilinx_dram_fifo.sv | 108 ++++++++++
 tb/tb_xilinx_dram_fifo.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/xilinx_dram_fifo_pkg.sv
// xilinx_dram_fifo_pkg: legal LUTRAM depths and pointer sizing shared by the FIFO files.
package xilinx_dram_fifo_pkg;

    localparam int DEPTH_LOG2_RAM32  = 5;
    localparam int DEPTH_LOG2_RAM64  = 6;
    localparam int DEPTH_LOG2_RAM128 = 7;

    function automatic int ptr_w(input int depth_log2);
        return depth_log2 + 1;
    endfunction

    function automatic bit depth_ok(input int depth_log2);
        return depth_log2 == DEPTH_LOG2_RAM32 || depth_log2 == DEPTH_LOG2_RAM64 ||
               depth_log2 == DEPTH_LOG2_RAM128;
    endfunction

endpackage

// File: rtl/xilinx_dram_fifo_mem.sv
// xilinx_dram_fifo_mem: bare sync-write/async-read array, one $__XILINX_RAM{32,64,128}X1D per bit.
module xilinx_dram_fifo_mem #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk1,
    input  logic                  b1_en,
    input  logic [DEPTH_LOG2-1:0] b1_addr,
    input  logic [WIDTH-1:0]      b1_data,
    input  logic [DEPTH_LOG2-1:0] a1_addr,
    output logic [WIDTH-1:0]      a1_data
);

    logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk1)
        if (b1_en) mem[b1_addr] <= b1_data;

    assign a1_data = mem[a1_addr];

endmodule

// File: rtl/xilinx_dram_fifo.sv
// xilinx_dram_fifo: single-clock FIFO on distributed RAM with a registered read stage.
// Define XILINX_DRAM_FIFO_ERR_EN to add sticky OVERFLOW/UNDERFLOW outputs.
module xilinx_dram_fifo
    import xilinx_dram_fifo_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEPTH_LOG2  = 6,
    parameter int AFULL_LEVEL = (1 << DEPTH_LOG2) - 4
) (
    input  logic                  CLK1,
    input  logic                  ARST,
    input  logic                  WR_EN,
    input  logic [WIDTH-1:0]      WR_DATA,
    output logic                  FULL,
    output logic                  ALMOST_FULL,
    input  logic                  RD_EN,
    output logic [WIDTH-1:0]      RD_DATA,
    output logic                  RD_VALID,
    output logic                  EMPTY,
`ifdef XILINX_DRAM_FIFO_ERR_EN
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW,
`endif
    output logic [DEPTH_LOG2:0]   COUNT
);

    typedef logic [ptr_w(DEPTH_LOG2)-1:0] ptr_t;

    localparam ptr_t AFULL = ptr_t'(AFULL_LEVEL);

    if (!depth_ok(DEPTH_LOG2)) begin : g_bad_depth
        $error("xilinx_dram_fifo: DEPTH_LOG2 must be 5, 6 or 7");
    end
    if (AFULL_LEVEL < 1 || AFULL_LEVEL > (1 << DEPTH_LOG2)) begin : g_bad_afull
        $error("xilinx_dram_fifo: AFULL_LEVEL out of range");
    end

    ptr_t             wptr_q, wptr_d, rptr_q, rptr_d, count;
    logic [WIDTH-1:0] rd_data_q, rd_data_d, a1_data;
    logic             rd_valid_q, rd_valid_d, wr_acc, rd_acc;

    assign count       = wptr_q - rptr_q;
    assign EMPTY       = wptr_q == rptr_q;
    assign FULL        = (wptr_q[DEPTH_LOG2-1:0] == rptr_q[DEPTH_LOG2-1:0]) &&
                         (wptr_q[DEPTH_LOG2] != rptr_q[DEPTH_LOG2]);
    assign ALMOST_FULL = count >= AFULL;
    assign COUNT       = count;
    assign RD_DATA     = rd_data_q;
    assign RD_VALID    = rd_valid_q;

    // A read while full frees the slot the simultaneous write lands in.
    always_comb begin
        wr_acc     = WR_EN && (!FULL || RD_EN);
        rd_acc     = RD_EN && !EMPTY;
        wptr_d     = wptr_q + ptr_t'(wr_acc);
        rptr_d     = rptr_q + ptr_t'(rd_acc);
        rd_valid_d = rd_acc;
        rd_data_d  = rd_acc ? a1_data : rd_data_q;
    end

    always_ff @(posedge CLK1 or posedge ARST) begin
        if (ARST) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    xilinx_dram_fifo_mem #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_mem (
        .clk1    (CLK1),
        .b1_en   (wr_acc),
        .b1_addr (wptr_q[DEPTH_LOG2-1:0]),
        .b1_data (WR_DATA),
        .a1_addr (rptr_q[DEPTH_LOG2-1:0]),
        .a1_data (a1_data)
    );

`ifdef XILINX_DRAM_FIFO_ERR_EN
    logic overflow_q, overflow_d, underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q || (WR_EN && FULL && !RD_EN);
        underflow_d = underflow_q || (RD_EN && EMPTY);
    end

    always_ff @(posedge CLK1 or posedge ARST) begin
        if (ARST) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign OVERFLOW  = overflow_q;
    assign UNDERFLOW = underflow_q;
`else
    // Rejected requests are dropped without any record.
`endif

endmodule

// File: tb/tb_xilinx_dram_fifo.sv
// tb_xilinx_dram_fifo: directed checks on a 64-deep FIFO plus randomized wrap runs on 32/128-deep ones.
// Error-flag checks are compiled in when XILINX_DRAM_FIFO_ERR_EN is defined.
module tb_xilinx_dram_fifo;

    logic       clk = 1'b0, arst = 1'b1;
    logic       wr6 = 1'b0, rd6 = 1'b0, wr_w = 1'b0, rd_w = 1'b0;
    logic [7:0] wd6 = '0, wd_w = '0;
    logic       full6, af6, rdv6, empty6, full5, af5, rdv5, empty5, full7, af7, rdv7, empty7;
    logic [7:0] rdd6, rdd5, rdd7;
    logic [6:0] cnt6;
    logic [5:0] cnt5;
    logic [7:0] cnt7;
`ifdef XILINX_DRAM_FIFO_ERR_EN
    logic       ovf6, udf6, ovf5, udf5, ovf7, udf7;
`endif

    int checks = 0, fails = 0;

    always #5 clk = ~clk;

    xilinx_dram_fifo #(.WIDTH(8), .DEPTH_LOG2(6)) dut6 (
        .CLK1(clk), .ARST(arst), .WR_EN(wr6), .WR_DATA(wd6), .FULL(full6), .ALMOST_FULL(af6),
        .RD_EN(rd6), .RD_DATA(rdd6), .RD_VALID(rdv6), .EMPTY(empty6),
`ifdef XILINX_DRAM_FIFO_ERR_EN
        .OVERFLOW(ovf6), .UNDERFLOW(udf6),
`endif
        .COUNT(cnt6));

    xilinx_dram_fifo #(.WIDTH(8), .DEPTH_LOG2(5)) dut5 (
        .CLK1(clk), .ARST(arst), .WR_EN(wr_w), .WR_DATA(wd_w), .FULL(full5), .ALMOST_FULL(af5),
        .RD_EN(rd_w), .RD_DATA(rdd5), .RD_VALID(rdv5), .EMPTY(empty5),
`ifdef XILINX_DRAM_FIFO_ERR_EN
        .OVERFLOW(ovf5), .UNDERFLOW(udf5),
`endif
        .COUNT(cnt5));

    xilinx_dram_fifo #(.WIDTH(8), .DEPTH_LOG2(7)) dut7 (
        .CLK1(clk), .ARST(arst), .WR_EN(wr_w), .WR_DATA(wd_w), .FULL(full7), .ALMOST_FULL(af7),
        .RD_EN(rd_w), .RD_DATA(rdd7), .RD_VALID(rdv7), .EMPTY(empty7),
`ifdef XILINX_DRAM_FIFO_ERR_EN
        .OVERFLOW(ovf7), .UNDERFLOW(udf7),
`endif
        .COUNT(cnt7));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] q5[$], q7[$];
    logic [7:0] e5, e7;
    bit         r5, w5, r7, w7, bias;

    initial begin
        e5 = '0;
        e7 = '0;
        repeat (2) step();
        arst = 1'b0;
        check("reset_empty", empty6, 1);
        check("reset_full", full6, 0);
        check("reset_af", af6, 0);
`ifdef XILINX_DRAM_FIFO_ERR_EN
        check("reset_ovf", ovf6, 0);
        check("reset_udf", udf6, 0);
`endif
        // Hold 5 entries with non-zero RD_DATA, then reset between edges.
        wr6 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wd6 = 8'h11 + 8'(i);
            step();
        end
        wr6 = 1'b0;
        rd6 = 1'b1;
        step();
        rd6 = 1'b0;
        check("pre_rst_data", rdd6, 8'h11);
        check("pre_rst_valid", rdv6, 1);
        check("pre_rst_count", cnt6, 5);
        #2 arst = 1'b1;
        #1;
        check("async_rst_empty", empty6, 1);
        check("async_rst_count", cnt6, 0);
        check("async_rst_valid", rdv6, 0);
        check("async_rst_data", rdd6, 0);
        arst = 1'b0;
        step();
        check("post_rst_empty", empty6, 1);
        check("post_rst_count", cnt6, 0);
        check("post_rst_data", rdd6, 0);

        // Fill 0x00..0x3F.
        wr6 = 1'b1;
        for (int i = 0; i < 64; i++) begin
            wd6 = 8'(i);
            step();
            if (i == 58) check("af_at_59", af6, 0);
            if (i == 59) check("af_at_60", af6, 1);
            if (i == 62) check("full_at_63", full6, 0);
        end
        wr6 = 1'b0;
        check("fill_full", full6, 1);
        check("fill_count", cnt6, 64);

        // Write and read together while full.
        wr6 = 1'b1;
        rd6 = 1'b1;
        wd6 = 8'hAA;
        step();
        wr6 = 1'b0;
        check("wr_rd_full_data", rdd6, 8'h00);
        check("wr_rd_full_valid", rdv6, 1);
        check("wr_rd_full_full", full6, 1);
        check("wr_rd_full_count", cnt6, 64);

        // Drain with RD_EN held.
        for (int i = 1; i < 64; i++) begin
            step();
            check("drain_data", rdd6, 32'(i));
            check("drain_valid", rdv6, 1);
        end
        step();
        check("drain_last_aa", rdd6, 8'hAA);
        check("drain_empty", empty6, 1);
        check("drain_af", af6, 0);
        step();
        rd6 = 1'b0;
        check("empty_rd_valid", rdv6, 0);
        check("empty_rd_hold", rdd6, 8'hAA);
`ifdef XILINX_DRAM_FIFO_ERR_EN
        check("underflow_set", udf6, 1);
        check("no_overflow", ovf6, 0);
`endif

        // Write and read together while empty.
        wr6 = 1'b1;
        rd6 = 1'b1;
        wd6 = 8'h55;
        step();
        wr6 = 1'b0;
        check("wr_rd_empty_valid", rdv6, 0);
        check("wr_rd_empty_count", cnt6, 1);
        check("wr_rd_empty_nempty", empty6, 0);
        step();
        rd6 = 1'b0;
        check("after_empty_data", rdd6, 8'h55);
        check("after_empty_valid", rdv6, 1);
        check("after_empty_empty", empty6, 1);

        // Write into a full FIFO with no read.
        wr6 = 1'b1;
        for (int i = 0; i < 64; i++) begin
            wd6 = 8'h80 + 8'(i);
            step();
        end
        wd6 = 8'hEE;
        step();
        wr6 = 1'b0;
        check("ovf_count", cnt6, 64);
        check("ovf_full", full6, 1);
`ifdef XILINX_DRAM_FIFO_ERR_EN
        check("overflow_set", ovf6, 1);
        check("underflow_sticky", udf6, 1);
`endif
        step();
`ifdef XILINX_DRAM_FIFO_ERR_EN
        check("overflow_sticky", ovf6, 1);
`endif
        rd6 = 1'b1;
        step();
        rd6 = 1'b0;
        check("ovf_oldest_kept", rdd6, 8'h80);
        check("ovf_count_after_rd", cnt6, 63);
        arst = 1'b1;
        step();
        arst = 1'b0;
        check("rst2_count", cnt6, 0);
        check("rst2_empty", empty6, 1);
`ifdef XILINX_DRAM_FIFO_ERR_EN
        check("rst2_ovf", ovf6, 0);
        check("rst2_udf", udf6, 0);
`endif

        // Random interleaving on 32- and 128-deep FIFOs against queue scoreboards.
        for (int c = 0; c < 1500; c++) begin
            bias = ((c / 250) % 2) == 0;
            wr_w = $urandom_range(0, 3) < (bias ? 3 : 1);
            rd_w = $urandom_range(0, 3) < (bias ? 1 : 3);
            wd_w = 8'($urandom);
            r5 = rd_w && q5.size() != 0;
            w5 = wr_w && (q5.size() != 32 || rd_w);
            r7 = rd_w && q7.size() != 0;
            w7 = wr_w && (q7.size() != 128 || rd_w);
            if (r5) e5 = q5.pop_front();
            if (w5) q5.push_back(wd_w);
            if (r7) e7 = q7.pop_front();
            if (w7) q7.push_back(wd_w);
            step();
            check("wrap5_valid", rdv5, r5);
            check("wrap5_data", rdd5, e5);
            check("wrap5_count", cnt5, q5.size());
            check("wrap7_valid", rdv7, r7);
            check("wrap7_data", rdd7, e7);
            check("wrap7_count", cnt7, q7.size());
        end
        wr_w = 1'b0;
        rd_w = 1'b0;

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
